// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
// The optional parity feature is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } rx_state_e;

  // One FIFO entry: parity error, framing error, received byte
  localparam int unsigned ENTRY_W = 10;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } rx_entry_t;

  // Clocks per oversample tick, rounded to nearest
  function automatic int unsigned div_calc(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic DEPTH x WIDTH first-word-fall-through FIFO with registered head,
// count, full and empty. The head register holds its last value when empty.
module uart_rx_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr_q, rd_ptr_q, count_q;
  logic [CW-1:0]    wr_ptr_d, rd_ptr_d, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q, empty_q;
  logic             push_c, pop_c;

  assign pop_c    = rd_en_i && valid_q;
  assign push_c   = wr_en_i && (!full_q || pop_c);
  assign wr_ptr_d = wr_ptr_q + CW'(push_c);
  assign rd_ptr_d = rd_ptr_q + CW'(pop_c);
  assign count_d  = count_q + CW'(push_c) - CW'(pop_c);

  // Next head: forward the incoming word when it lands in the new head slot
  always_comb begin
    head_d = head_q;
    if (count_d != '0) begin
      if (push_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = wr_data_i;
      end else begin
        head_d = mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointers, occupancy and registered status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = valid_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered 8-bit LSB-first UART receiver with framing/break detection and an
// FWFT receive FIFO. Define UART_RX_PARITY_EN to receive an even-parity bit.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic                          rd_frame_err,
  output logic                          rd_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_err,
  output logic                          break_det,
  output logic                          rx_busy
);

  localparam int unsigned DIV   = div_calc(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] MID = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic [1:0]       sync_q;
  logic             rxs;

  rx_state_e        state_q;
  logic [OS_W-1:0]  os_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             push_q;
  rx_entry_t        push_entry_q;
  logic             break_det_q;
  logic             rx_busy_q;
  logic             overflow_q;
  logic             sample_c;
  logic             pe_c;

  rx_entry_t        head;
  logic             fifo_full, fifo_empty;
  logic             drop_c;

  // Free-running oversample tick divider
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (div_q == DIV_W'(DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick_c = (div_q == DIV_W'(DIV - 1));

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxs      = sync_q[1];
  assign sample_c = tick_c && (os_cnt_q == MID);

`ifdef UART_RX_PARITY_EN
  logic par_q;
  assign pe_c = ^shift_q ^ par_q;
`else
  assign pe_c = 1'b0;
`endif

  // Frame receiver FSM with registered push/break/busy outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      break_det_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      break_det_q <= 1'b0;
      if (tick_c && (state_q != IDLE)) begin
        os_cnt_q <= os_cnt_q + OS_W'(1);
      end
      case (state_q)
        IDLE: begin
          os_cnt_q <= '0;
          if (!rxs) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (sample_c) begin
            if (rxs) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (sample_c) begin
            shift_q   <= {rxs, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_c) begin
            par_q   <= rxs;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample_c) begin
            if (rxs) begin
              push_q            <= 1'b1;
              push_entry_q.pe   <= pe_c;
              push_entry_q.fe   <= 1'b0;
              push_entry_q.data <= shift_q;
              state_q           <= IDLE;
              rx_busy_q         <= 1'b0;
            end else if (shift_q != 8'h00) begin
              push_q            <= 1'b1;
              push_entry_q.pe   <= pe_c;
              push_entry_q.fe   <= 1'b1;
              push_entry_q.data <= shift_q;
              state_q           <= BRKWAIT;
            end else begin
              break_det_q <= 1'b1;
              state_q     <= BRKWAIT;
            end
          end
        end
        BRKWAIT: begin
          if (rxs) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (push_q),
    .wr_data_i  (push_entry_q),
    .rd_en_i    (rd_en),
    .rd_data_o  (head),
    .rd_valid_o (rd_valid),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // A push is lost only when full and no pop frees a slot in the same cycle
  assign drop_c = push_q && fifo_full && !(rd_en && !fifo_empty);

  // Sticky overflow; a drop in the same cycle beats clr_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end else if (clr_err) begin
      overflow_q <= 1'b0;
    end
  end

  assign rd_data      = head.data;
  assign rd_frame_err = head.fe;
  assign overflow     = overflow_q;
  assign break_det    = break_det_q;
  assign rx_busy      = rx_busy_q;

`ifdef UART_RX_PARITY_EN
  assign rd_parity_err = head.pe;
`else
  logic unused_pe;
  assign unused_pe     = head.pe;
  assign rd_parity_err = 1'b0;
`endif

endmodule
